llc_rst_flush_sweep: RTL and testbench

// - Sequencer that walks every LLC set during reset or flush.
// - Drives the set-counter and stall-clear strobes of the LLC register block, which owns rst_flush_stalled_set, rst_stall and flush_stall.
// - Reset mode: zero-writes every set. Flush mode: reads each set, writes back dirty valid ways to memory, then invalidates every valid way.
// - Sits between the LLC register block and the tag/state RAM + memory request path.

---
 rtl/llc_rst_flush_sweep_pkg.sv | 38 +++
 rtl/llc_rst_flush_sweep.sv | 172 +++++++++++++++++
 tb/tb_llc_rst_flush_sweep.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/llc_rst_flush_sweep_pkg.sv
// Shared LLC widths, state encodings and the reset/flush sweep FSM states.
package llc_rst_flush_sweep_pkg;

    localparam int LLC_SETS     = 4;
    localparam int LLC_WAYS     = 4;
    localparam int LLC_WAY_BITS = 2;
    localparam int LLC_SET_BITS = 2;
    localparam int LLC_TAG_BITS = 8;

    typedef logic [LLC_SET_BITS-1:0] llc_set_t;
    typedef logic [LLC_WAY_BITS-1:0] llc_way_t;
    typedef logic [LLC_TAG_BITS-1:0] llc_tag_t;

    typedef enum logic [1:0] {
        INVALID   = 2'd0,
        SHARED    = 2'd1,
        EXCLUSIVE = 2'd2,
        MODIFIED  = 2'd3
    } llc_state_t;

    typedef struct packed {
        llc_tag_t tag;
        llc_set_t set;
    } line_addr_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST_WR,
        S_RD_SET,
        S_LATCH,
        S_SCAN,
        S_WB,
        S_INV,
        S_NEXT,
        S_DONE
    } sweep_state_t;

endpackage

// File: rtl/llc_rst_flush_sweep.sv
// Walks every LLC set: zero-write on reset, writeback-dirty + invalidate on flush.
// Latency: reset sweep 2*SETS+1 cycles; clean flush set RD_SET+LATCH+WAYS scans+NEXT.
// Backpressure: WB holds wb_valid/wb_addr until wb_ready; no other stalls.
module llc_rst_flush_sweep
    import llc_rst_flush_sweep_pkg::*;
#(
    parameter int SETS     = LLC_SETS,
    parameter int WAYS     = LLC_WAYS,
    parameter int WAY_BITS = LLC_WAY_BITS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rst_state,
    input  logic       rst_stall,
    input  logic       flush_stall,
    input  llc_set_t   rst_flush_stalled_set,
    input  llc_state_t states_buf     [WAYS],
    input  logic       dirty_bits_buf [WAYS],
    input  llc_tag_t   tags_buf       [WAYS],
    output logic       rd_set_en,
    output logic       wr_rst_set,
    output logic       wr_inv_en,
    output llc_way_t   wr_way,
    output logic       wb_valid,
    input  logic       wb_ready,
    output line_addr_t wb_addr,
    output logic       incr_rst_flush_stalled_set,
    output logic       clr_rst_flush_stalled_set,
    output logic       clr_rst_stall,
    output logic       clr_flush_stall,
    output logic       sweep_busy
);

    sweep_state_t        state;
    sweep_state_t        state_nxt;
    logic [WAY_BITS-1:0] way_ptr;
    logic                way_adv;
    logic                mode_flush;
    logic                last_way;
    logic                last_set;

    llc_state_t lat_state [WAYS];
    logic       lat_dirty [WAYS];
    llc_tag_t   lat_tag   [WAYS];

    assign last_way   = (way_ptr == WAY_BITS'(WAYS - 1));
    assign last_set   = (rst_flush_stalled_set == llc_set_t'(SETS - 1));
    assign sweep_busy = (state != S_IDLE);
    assign wr_way     = (state == S_INV) ? llc_way_t'(way_ptr) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            way_ptr    <= '0;
            mode_flush <= 1'b0;
            wb_valid   <= 1'b0;
            wb_addr    <= '0;
            for (int w = 0; w < WAYS; w++) begin
                lat_state[w] <= INVALID;
                lat_dirty[w] <= 1'b0;
                lat_tag[w]   <= '0;
            end
        end else if (rst_state) begin
            state      <= S_IDLE;
            way_ptr    <= '0;
            mode_flush <= 1'b0;
            wb_valid   <= 1'b0;
            wb_addr    <= '0;
            for (int w = 0; w < WAYS; w++) begin
                lat_state[w] <= INVALID;
                lat_dirty[w] <= 1'b0;
                lat_tag[w]   <= '0;
            end
        end else begin
            state <= state_nxt;
            // Mode is frozen for the whole sweep; reset wins a tie.
            if (state == S_IDLE && state_nxt != S_IDLE) begin
                mode_flush <= !rst_stall;
            end
            if (state == S_LATCH) begin
                for (int w = 0; w < WAYS; w++) begin
                    lat_state[w] <= states_buf[w];
                    lat_dirty[w] <= dirty_bits_buf[w];
                    lat_tag[w]   <= tags_buf[w];
                end
                way_ptr <= '0;
            end else if (way_adv) begin
                way_ptr <= way_ptr + 1'b1;
            end
            if (state == S_SCAN && state_nxt == S_WB) begin
                wb_valid <= 1'b1;
                wb_addr  <= '{tag: lat_tag[way_ptr], set: rst_flush_stalled_set};
            end else if (state == S_WB && wb_ready) begin
                wb_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt                  = state;
        way_adv                    = 1'b0;
        rd_set_en                  = 1'b0;
        wr_rst_set                 = 1'b0;
        wr_inv_en                  = 1'b0;
        incr_rst_flush_stalled_set = 1'b0;
        clr_rst_flush_stalled_set  = 1'b0;
        clr_rst_stall              = 1'b0;
        clr_flush_stall            = 1'b0;
        case (state)
            S_IDLE: begin
                if (rst_stall) begin
                    state_nxt = S_RST_WR;
                end else if (flush_stall) begin
                    state_nxt = S_RD_SET;
                end
            end
            S_RST_WR: begin
                wr_rst_set = 1'b1;
                state_nxt  = S_NEXT;
            end
            S_RD_SET: begin
                rd_set_en = 1'b1;
                state_nxt = S_LATCH;
            end
            S_LATCH: begin
                state_nxt = S_SCAN;
            end
            S_SCAN: begin
                if (lat_state[way_ptr] != INVALID) begin
                    state_nxt = lat_dirty[way_ptr] ? S_WB : S_INV;
                end else if (last_way) begin
                    state_nxt = S_NEXT;
                end else begin
                    way_adv = 1'b1;
                end
            end
            S_WB: begin
                if (wb_valid && wb_ready) begin
                    state_nxt = S_INV;
                end
            end
            S_INV: begin
                wr_inv_en = 1'b1;
                if (last_way) begin
                    state_nxt = S_NEXT;
                end else begin
                    way_adv   = 1'b1;
                    state_nxt = S_SCAN;
                end
            end
            S_NEXT: begin
                if (last_set) begin
                    state_nxt = S_DONE;
                end else begin
                    // Register block bumps the set on this edge, ready for the next RST_WR/RD_SET.
                    incr_rst_flush_stalled_set = 1'b1;
                    state_nxt = mode_flush ? S_RD_SET : S_RST_WR;
                end
            end
            S_DONE: begin
                clr_rst_flush_stalled_set = 1'b1;
                clr_rst_stall             = !mode_flush;
                clr_flush_stall           = mode_flush;
                state_nxt                 = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_llc_rst_flush_sweep.sv
// Directed bench: register-block and tag-RAM models around the sweep FSM.
module tb_llc_rst_flush_sweep;
    import llc_rst_flush_sweep_pkg::*;

    logic       clk;
    logic       rst;
    logic       rst_state;
    logic       rst_stall;
    logic       flush_stall;
    llc_set_t   cur_set;
    llc_state_t states_buf     [LLC_WAYS];
    logic       dirty_bits_buf [LLC_WAYS];
    llc_tag_t   tags_buf       [LLC_WAYS];
    logic       rd_set_en;
    logic       wr_rst_set;
    logic       wr_inv_en;
    llc_way_t   wr_way;
    logic       wb_valid;
    logic       wb_ready;
    line_addr_t wb_addr;
    logic       incr_set;
    logic       clr_set;
    logic       clr_rst_stall;
    logic       clr_flush_stall;
    logic       sweep_busy;

    logic       req_rst;
    logic       req_flush;
    logic       model_clr;
    llc_state_t mem_state [LLC_SETS][LLC_WAYS];
    logic       mem_dirty [LLC_SETS][LLC_WAYS];
    llc_tag_t   mem_tag   [LLC_SETS][LLC_WAYS];

    int checks;
    int errors;

    logic [8:0] strobes;
    assign strobes = {rd_set_en, wr_rst_set, wr_inv_en, wb_valid, incr_set,
                      clr_set, clr_rst_stall, clr_flush_stall, sweep_busy};

    llc_rst_flush_sweep dut (
        .clk                        (clk),
        .rst                        (rst),
        .rst_state                  (rst_state),
        .rst_stall                  (rst_stall),
        .flush_stall                (flush_stall),
        .rst_flush_stalled_set      (cur_set),
        .states_buf                 (states_buf),
        .dirty_bits_buf             (dirty_bits_buf),
        .tags_buf                   (tags_buf),
        .rd_set_en                  (rd_set_en),
        .wr_rst_set                 (wr_rst_set),
        .wr_inv_en                  (wr_inv_en),
        .wr_way                     (wr_way),
        .wb_valid                   (wb_valid),
        .wb_ready                   (wb_ready),
        .wb_addr                    (wb_addr),
        .incr_rst_flush_stalled_set (incr_set),
        .clr_rst_flush_stalled_set  (clr_set),
        .clr_rst_stall              (clr_rst_stall),
        .clr_flush_stall            (clr_flush_stall),
        .sweep_busy                 (sweep_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register block (stall flags + set counter) and tag RAM with one-cycle read.
    always @(posedge clk) begin
        if (model_clr) begin
            rst_stall   <= 1'b0;
            flush_stall <= 1'b0;
            cur_set     <= '0;
        end else begin
            if (req_rst) rst_stall <= 1'b1;
            else if (clr_rst_stall) rst_stall <= 1'b0;
            if (req_flush) flush_stall <= 1'b1;
            else if (clr_flush_stall) flush_stall <= 1'b0;
            if (clr_set) cur_set <= '0;
            else if (incr_set) cur_set <= cur_set + 1'b1;
        end
        if (rd_set_en) begin
            for (int w = 0; w < LLC_WAYS; w++) begin
                states_buf[w]     <= mem_state[cur_set][w];
                dirty_bits_buf[w] <= mem_dirty[cur_set][w];
                tags_buf[w]       <= mem_tag[cur_set][w];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int s = 0; s < LLC_SETS; s++) begin
            for (int w = 0; w < LLC_WAYS; w++) begin
                mem_state[s][w] = INVALID;
                mem_dirty[s][w] = 1'b0;
                mem_tag[s][w]   = '0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (strobes !== 9'b0 || wr_way !== '0 || wb_addr !== '0) begin
            errors++;
            $display("FAIL reset_outputs: strobes=%b wr_way=%0d wb_addr=%h, required all 0", strobes, wr_way, wb_addr);
        end
        tick();
        tick();
        rst = 1'b1;
        model_clr = 1'b0;
        tick();
        checks++;
        if (strobes !== 9'b0 || cur_set !== '0) begin
            errors++;
            $display("FAIL reset_idle: strobes=%b set=%0d, required 0/0", strobes, cur_set);
        end
    endtask

    task automatic test_reset_sweep();
        int first = -1;
        int done  = -1;
        int nrst  = 0;
        int ninc  = 0;
        req_rst = 1'b1;
        tick();
        req_rst = 1'b0;
        for (int i = 0; i < 40 && done < 0; i++) begin
            tick();
            if (wr_rst_set) begin
                if (first < 0) first = i;
                checks++;
                if (cur_set !== llc_set_t'(nrst)) begin
                    errors++;
                    $display("FAIL rst_sweep_set: got set %0d, required %0d", cur_set, nrst);
                end
                nrst++;
            end
            if (incr_set) ninc++;
            if (clr_rst_stall) begin
                done = i;
                checks++;
                if (clr_set !== 1'b1 || clr_flush_stall !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_sweep_done: clr_set=%b clr_flush=%b, required 1/0", clr_set, clr_flush_stall);
                end
            end
        end
        checks++;
        if (done < 0) begin
            errors++;
            $display("FAIL rst_sweep_timeout: clr_rst_stall not seen within 40 cycles");
        end else if (done - first + 1 != 2 * LLC_SETS + 1) begin
            errors++;
            $display("FAIL rst_sweep_cycles: got %0d, required %0d", done - first + 1, 2 * LLC_SETS + 1);
        end
        checks++;
        if (nrst != LLC_SETS || ninc != LLC_SETS - 1) begin
            errors++;
            $display("FAIL rst_sweep_counts: wr_rst_set=%0d incr=%0d, required %0d/%0d", nrst, ninc, LLC_SETS, LLC_SETS - 1);
        end
        tick();
        checks++;
        if (sweep_busy !== 1'b0 || rst_stall !== 1'b0 || cur_set !== '0) begin
            errors++;
            $display("FAIL rst_sweep_after: busy=%b rst_stall=%b set=%0d, required 0/0/0", sweep_busy, rst_stall, cur_set);
        end
    endtask

    task automatic test_flush_dirty();
        line_addr_t exp_addr;
        int wbcnt   = 0;
        int ninv    = 0;
        int done    = -1;
        int last_wb = -100;
        clear_mem();
        mem_state[0][2] = MODIFIED;
        mem_dirty[0][2] = 1'b1;
        mem_tag[0][2]   = 8'h1A;
        mem_state[1][0] = SHARED;
        mem_tag[1][0]   = 8'h05;
        exp_addr = '{tag: 8'h1A, set: 2'd0};
        wb_ready  = 1'b0;
        req_flush = 1'b1;
        tick();
        req_flush = 1'b0;
        for (int i = 0; i < 120 && done < 0; i++) begin
            tick();
            wb_ready = 1'b0;
            if (wb_valid) begin
                wbcnt++;
                last_wb = i;
                checks++;
                if (wb_addr !== exp_addr) begin
                    errors++;
                    $display("FAIL flush_wb_addr: got %h, required %h", wb_addr, exp_addr);
                end
                if (wbcnt == 4) wb_ready = 1'b1;
            end
            if (wr_inv_en) begin
                checks++;
                if (ninv == 0) begin
                    if (cur_set !== 2'd0 || wr_way !== 2'd2 || last_wb != i - 1) begin
                        errors++;
                        $display("FAIL flush_inv_after_wb: set=%0d way=%0d gap=%0d, required 0/2/1", cur_set, wr_way, i - last_wb);
                    end
                end else if (cur_set !== 2'd1 || wr_way !== 2'd0) begin
                    errors++;
                    $display("FAIL flush_inv_clean: set=%0d way=%0d, required 1/0", cur_set, wr_way);
                end
                ninv++;
            end
            if (clr_flush_stall) done = i;
        end
        wb_ready = 1'b0;
        checks++;
        if (wbcnt != 4) begin
            errors++;
            $display("FAIL flush_wb_hold: wb_valid high %0d cycles, required 4", wbcnt);
        end
        checks++;
        if (ninv != 2 || done < 0) begin
            errors++;
            $display("FAIL flush_dirty_done: inv=%0d done=%0d, required 2 and completion", ninv, done);
        end
        tick();
    endtask

    task automatic test_flush_clean();
        int first = -1;
        int done  = -1;
        int nrd   = 0;
        int nwb   = 0;
        int ninv  = 0;
        clear_mem();
        req_flush = 1'b1;
        tick();
        req_flush = 1'b0;
        for (int i = 0; i < 100 && done < 0; i++) begin
            tick();
            if (rd_set_en) begin
                if (first < 0) first = i;
                nrd++;
            end
            if (wb_valid) nwb++;
            if (wr_inv_en) ninv++;
            if (clr_flush_stall) done = i;
        end
        checks++;
        if (nwb != 0 || ninv != 0 || nrd != LLC_SETS) begin
            errors++;
            $display("FAIL flush_clean_counts: wb=%0d inv=%0d rd=%0d, required 0/0/%0d", nwb, ninv, nrd, LLC_SETS);
        end
        // Per set: RD_SET, LATCH, one SCAN per way, NEXT; then a final DONE.
        checks++;
        if (done < 0 || done - first + 1 != LLC_SETS * (LLC_WAYS + 3) + 1) begin
            errors++;
            $display("FAIL flush_clean_cycles: got %0d, required %0d", done - first + 1, LLC_SETS * (LLC_WAYS + 3) + 1);
        end
        tick();
    endtask

    task automatic test_both_stalls();
        int nrd   = 0;
        int nrst  = 0;
        int done  = -1;
        int fdone = -1;
        clear_mem();
        req_rst   = 1'b1;
        req_flush = 1'b1;
        tick();
        req_rst   = 1'b0;
        req_flush = 1'b0;
        for (int i = 0; i < 40 && done < 0; i++) begin
            tick();
            if (rd_set_en) nrd++;
            if (wr_rst_set) nrst++;
            if (clr_flush_stall) fdone = i;
            if (clr_rst_stall) done = i;
        end
        checks++;
        if (done < 0 || nrd != 0 || nrst != LLC_SETS || fdone >= 0) begin
            errors++;
            $display("FAIL both_stalls_reset_first: done=%0d rd=%0d rst_wr=%0d flush_done=%0d", done, nrd, nrst, fdone);
        end
        for (int i = 0; i < 60 && fdone < 0; i++) begin
            tick();
            if (clr_flush_stall) fdone = i;
        end
        checks++;
        if (fdone < 0) begin
            errors++;
            $display("FAIL both_stalls_flush_after: clr_flush_stall not seen within 60 cycles");
        end
        tick();
    endtask

    task automatic test_rst_state_in_wb();
        int seen = 0;
        clear_mem();
        mem_state[0][1] = MODIFIED;
        mem_dirty[0][1] = 1'b1;
        mem_tag[0][1]   = 8'h33;
        wb_ready  = 1'b0;
        req_flush = 1'b1;
        tick();
        req_flush = 1'b0;
        for (int i = 0; i < 30 && seen == 0; i++) begin
            tick();
            if (wb_valid) seen = 1;
        end
        rst_state = 1'b1;
        model_clr = 1'b1;
        tick();
        rst_state = 1'b0;
        model_clr = 1'b0;
        checks++;
        if (seen == 0 || wb_valid !== 1'b0 || sweep_busy !== 1'b0 || strobes !== 9'b0) begin
            errors++;
            $display("FAIL rst_state_wb: seen=%0d wb_valid=%b busy=%b strobes=%b, required 1/0/0/0", seen, wb_valid, sweep_busy, strobes);
        end
        tick();
        tick();
        checks++;
        if (sweep_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_state_stays_idle: busy=%b, required 0", sweep_busy);
        end
    endtask

    task automatic test_async_rst_mid_scan();
        int seen = 0;
        int done = -1;
        int nrst = 0;
        clear_mem();
        mem_state[0][3] = EXCLUSIVE;
        req_flush = 1'b1;
        tick();
        req_flush = 1'b0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            tick();
            if (rd_set_en) seen = 1;
        end
        tick();
        tick();
        checks++;
        if (seen == 0 || sweep_busy !== 1'b1) begin
            errors++;
            $display("FAIL async_rst_setup: rd_seen=%0d busy=%b, required 1/1", seen, sweep_busy);
        end
        #2;
        rst = 1'b0;
        model_clr = 1'b1;
        #1;
        checks++;
        if (strobes !== 9'b0 || wr_way !== '0 || wb_addr !== '0) begin
            errors++;
            $display("FAIL async_rst_outputs: strobes=%b wr_way=%0d wb_addr=%h, required all 0", strobes, wr_way, wb_addr);
        end
        tick();
        tick();
        rst = 1'b1;
        model_clr = 1'b0;
        tick();
        req_rst = 1'b1;
        tick();
        req_rst = 1'b0;
        for (int i = 0; i < 40 && done < 0; i++) begin
            tick();
            if (wr_rst_set) nrst++;
            if (clr_rst_stall) done = i;
        end
        checks++;
        if (done < 0 || nrst != LLC_SETS) begin
            errors++;
            $display("FAIL async_rst_resume: done=%0d rst_wr=%0d, required completion and %0d", done, nrst, LLC_SETS);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_state = 1'b0;
        wb_ready  = 1'b0;
        req_rst   = 1'b0;
        req_flush = 1'b0;
        model_clr = 1'b1;
        clear_mem();
        test_reset();
        test_reset_sweep();
        test_flush_dirty();
        test_flush_clean();
        test_both_stalls();
        test_rst_state_in_wb();
        test_async_rst_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
